bit_deserializer: RTL and testbench

Serial-to-parallel stage placed directly upstream of the priority encoder. It collects single bits, MSB first, into a DATA_W-bit word. It then presents the word for one cycle with a valid strobe, which drives the encoder's data_i/data_val_i. A flush input emits a partially filled word, so bursts that are not a multiple of DATA_W still reach the encoder.

---
 rtl/bit_deserializer.sv | 74 +++++++
 tb/tb_bit_deserializer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bit_deserializer.sv
// Serial-to-parallel front end for the priority encoder: packs bits MSB first
// into DATA_W-bit words and strobes each word (full or flushed) for one cycle.
//
// Ports:
//   clk_i            - clock, all logic on posedge
//   srst_i           - synchronous active-high reset
//   data_i           - serial data bit
//   data_val_i       - data_i valid this cycle
//   flush_i          - emit the current partial word
//   deser_data_o     - assembled word, first bit at DATA_W-1
//   deser_cnt_o      - number of valid bits in deser_data_o
//   deser_data_val_o - one-cycle strobe for deser_data_o/deser_cnt_o
module bit_deserializer #(
    parameter  int DATA_W = 16,
    localparam int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              data_i,
    input  logic              data_val_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] deser_data_o,
    output logic [CNT_W-1:0]  deser_cnt_o,
    output logic              deser_data_val_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] sr;
    logic [CNT_W-1:0]  cnt;

    logic [DATA_W-1:0] sr_ins;
    logic [CNT_W-1:0]  cnt_ins;
    logic              full;
    logic              emit;

    // Word as it stands after this cycle's bit (if any) is taken in.
    // A flush in the same cycle therefore includes that bit.
    always_comb begin
        sr_ins = sr;
        for (int i = 0; i < DATA_W; i++) begin
            if (data_val_i && (CNT_W'(DATA_W - 1 - i) == cnt)) begin
                sr_ins[i] = data_i;
            end
        end
        cnt_ins = cnt + {{(CNT_W-1){1'b0}}, data_val_i};
    end

    // A flush that lands on a completing word folds into that single strobe;
    // a flush with nothing pending is dropped.
    assign full = data_val_i && (cnt == LAST);
    assign emit = full || (flush_i && (cnt_ins != '0));

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            sr               <= '0;
            cnt              <= '0;
            deser_data_o     <= '0;
            deser_cnt_o      <= '0;
            deser_data_val_o <= 1'b0;
        end else if (emit) begin
            sr               <= '0;
            cnt              <= '0;
            deser_data_o     <= sr_ins;
            deser_cnt_o      <= cnt_ins;
            deser_data_val_o <= 1'b1;
        end else begin
            sr               <= sr_ins;
            cnt              <= cnt_ins;
            deser_data_val_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bit_deserializer.sv
// Scoreboard bench for bit_deserializer: directed scenarios with fixed
// expectations, then random traffic against a bit-queue reference model.
module tb_bit_deserializer;

    localparam int W  = 16;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          srst = 1'b1;
    logic          din = 1'b0;
    logic          dval = 1'b0;
    logic          flush = 1'b0;
    logic [W-1:0]  dout;
    logic [CW-1:0] dcnt;
    logic          dstb;

    bit_deserializer #(.DATA_W(W)) dut (
        .clk_i            (clk),
        .srst_i           (srst),
        .data_i           (din),
        .data_val_i       (dval),
        .flush_i          (flush),
        .deser_data_o     (dout),
        .deser_cnt_o      (dcnt),
        .deser_data_val_o (dstb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        int           cnt;
    } exp_t;

    exp_t exp_q[$];
    bit   pend[$];
    bit   auto_exp = 1'b0;
    bit   done = 1'b0;
    int   vectors = 0;
    int   errs = 0;

    // Reference model: bits collected in a queue, a word is emitted when
    // W bits are held or when a flush finds at least one bit held.
    task automatic model(input bit v, input bit d, input bit f, input bit r);
        exp_t e;
        if (r) begin
            pend.delete();
            return;
        end
        if (v) pend.push_back(d);
        if (pend.size() == W || (f && pend.size() > 0)) begin
            e.data = '0;
            foreach (pend[i]) e.data[W-1-i] = pend[i];
            e.cnt = pend.size();
            exp_q.push_back(e);
            pend.delete();
        end
    endtask

    task automatic step(input bit v, input bit d, input bit f, input bit r);
        dval  = v;
        din   = d;
        flush = f;
        srst  = r;
        @(posedge clk);
        if (auto_exp) model(v, d, f, r);
        #1;
    endtask

    task automatic expect_word(input logic [W-1:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cnt  = c;
        exp_q.push_back(e);
    endtask

    task automatic send_word(input logic [W-1:0] w, input int n);
        for (int i = 0; i < n; i++) step(1'b1, w[W-1-i], 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: pops on every strobe; between strobes outputs must hold the
    // last emitted values (zero after reset).
    logic [W-1:0] last_d = '0;
    int           last_c = 0;
    bit           rst_pend = 1'b1;

    always @(negedge clk) begin
        exp_t e;
        if (!done) begin
            if (rst_pend) begin
                last_d = '0;
                last_c = 0;
            end
            vectors++;
            if (dstb) begin
                if (rst_pend) begin
                    errs++;
                    $display("FAIL strobe_after_reset: strobe=1 required 0");
                end else if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_strobe: data=%h cnt=%0d required no strobe",
                             dout, dcnt);
                end else begin
                    e = exp_q.pop_front();
                    if (dout !== e.data || int'(dcnt) != e.cnt) begin
                        errs++;
                        $display("FAIL word: data=%h cnt=%0d required data=%h cnt=%0d",
                                 dout, dcnt, e.data, e.cnt);
                    end
                    last_d = e.data;
                    last_c = e.cnt;
                end
            end else if (dout !== last_d || int'(dcnt) != last_c) begin
                errs++;
                $display("FAIL hold: data=%h cnt=%0d required data=%h cnt=%0d",
                         dout, dcnt, last_d, last_c);
            end
            rst_pend = srst;
        end
    end

    initial begin
        int r;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // single full word
        expect_word(16'h8001, 16);
        send_word(16'h8001, 16);
        idle(3);

        // two back-to-back words
        expect_word(16'hA5A5, 16);
        expect_word(16'h0F0F, 16);
        send_word(16'hA5A5, 16);
        send_word(16'h0F0F, 16);
        idle(2);

        // gapped partial word, flush, then empty flush
        expect_word(16'hD800, 5);
        begin
            logic [4:0] b;
            b = 5'b11011;
            for (int i = 0; i < 5; i++) begin
                step(1'b1, b[4-i], 1'b0, 1'b0);
                idle(i % 4);
            end
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // flush together with a bit
        expect_word(16'hB000, 4);
        send_word(16'hA000, 3);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        idle(2);

        // flush on the completing bit, then zeros
        expect_word(16'hFFFF, 16);
        expect_word(16'h0000, 16);
        send_word(16'hFFFF, 15);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        send_word(16'h0000, 16);
        idle(2);

        // partial word discarded by reset
        expect_word(16'h1234, 16);
        send_word(16'hFE00, 7);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        send_word(16'h1234, 16);
        idle(2);

        // random traffic against the model
        auto_exp = 1'b1;
        pend.delete();
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            step(($urandom_range(0, 9) < 7), 1'($urandom),
                 ($urandom_range(0, 19) == 0), (r == 0));
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        auto_exp = 1'b0;
        idle(3);

        @(negedge clk);
        #1;
        done = 1'b1;
        vectors++;
        if (exp_q.size() != 0) begin
            errs++;
            $display("FAIL missing_strobes: pending=%0d required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
